// File: rtl/alu_tb_pkg.sv
// Shared definitions for the ALU stimulus path: FSM states, LFSR constants
// and the lane helpers used by the vector generator.
package alu_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [31:0] LANE_SALT = 32'h9E3779B9;

    function automatic int lane_count(input int width);
        return (width + 31) / 32;
    endfunction

    // Galois right-shift step; the mask's top bit re-injects the shifted-out bit.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced.
    function automatic logic [31:0] fix_seed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/alu_vector_gen_if.sv
// Valid/ready vector channel between the stimulus generator and the ALU.
interface alu_vector_gen_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic             valid;
    logic             ready;

    modport master (output a, b, op, valid, input ready);
    modport slave  (input a, b, op, valid, output ready);
endinterface

// File: rtl/Set_Check.sv
// Elaboration-time guard on the vectors-per-run count (legal 1..1000).
module Set_Check #(
    parameter int SETS = 16
) ();
    if (SETS < 1 || SETS > 1000) begin : g_bad_sets
        $error("Set_Check: SETS=%0d outside 1..1000", SETS);
    end
endmodule

// File: rtl/Width_Check.sv
// Elaboration-time guard on the operand width (legal 1..1024).
module Width_Check #(
    parameter int WIDTH = 8
) ();
    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
        $error("Width_Check: WIDTH=%0d outside 1..1024", WIDTH);
    end
endmodule

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous reload and advance-on-demand.
module lfsr32
    import alu_tb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= seed;
        else if (load)
            state <= seed;
        else if (adv)
            state <= lfsr_step(state);
    end

endmodule

// File: rtl/alu_vector_gen.sv
// Emits SETS operand/opcode vectors per start over a valid/ready channel.
// Define ALU_VECGEN_CORNER_EN to prefix each run with fixed corner vectors.
module alu_vector_gen
    import alu_tb_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter int          SETS    = 16,
    parameter int          NUM_OPS = 8,
    parameter logic [31:0] SEED    = 32'h1,
    localparam int         OP_W    = $clog2(NUM_OPS),
    localparam int         CNT_W   = $clog2(SETS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    alu_vector_gen_if.master       vec,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       count
);

    localparam int          LANES  = lane_count(WIDTH);
    localparam logic [31:0] SEED_A = fix_seed(SEED);
    localparam logic [31:0] SEED_B = fix_seed(~SEED);
`ifdef ALU_VECGEN_CORNER_EN
    localparam int          CORNERS = (SETS < 4) ? SETS : 4;
`endif

    gen_state_t       state, next_state;
    logic [31:0]      lfsr_a, lfsr_b, src_a, src_b;
    logic [WIDTH-1:0] a_q, b_q, vec_a, vec_b;
    logic [OP_W-1:0]  op_q;
    logic             accept, enter_run, last, cur_random;

    Width_Check #(WIDTH) u_width_check ();
    Set_Check   #(SETS)  u_set_check ();

    lfsr32 u_lfsr_a (.clk(clk), .rst_n(rst_n), .load(enter_run), .seed(SEED_A),
                     .adv(accept && cur_random), .state(lfsr_a));
    lfsr32 u_lfsr_b (.clk(clk), .rst_n(rst_n), .load(enter_run), .seed(SEED_B),
                     .adv(accept && cur_random), .state(lfsr_b));

    // Replicate the LFSR word into salted 32-bit lanes, lane 0 in the LSBs.
    function automatic logic [WIDTH-1:0] lanes(input logic [31:0] s);
        logic [WIDTH-1:0] r;
        logic [31:0]      lane;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            lane = s ^ (32'(k) * LANE_SALT);
            for (int j = 0; j < 32; j++)
                if (k * 32 + j < WIDTH) r[k * 32 + j] = lane[j];
        end
        return r;
    endfunction

    assign accept    = (state == RUN) && vec.ready;
    assign enter_run = start && (state != RUN);
    assign last      = (count == CNT_W'(SETS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN: begin
                busy = 1'b1;
                if (accept && last) next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    // Next vector to present: vector 0 from the seeds on run entry, otherwise
    // the LFSR value it will hold after this accept.
    always_comb begin
        src_a      = lfsr_step(lfsr_a);
        src_b      = lfsr_step(lfsr_b);
        cur_random = 1'b1;
`ifdef ALU_VECGEN_CORNER_EN
        cur_random = (int'(count) >= CORNERS);
        if (!cur_random) begin
            src_a = lfsr_a;
            src_b = lfsr_b;
        end
`endif
        if (enter_run) begin
            src_a = SEED_A;
            src_b = SEED_B;
        end
        vec_a = lanes(src_a);
        vec_b = lanes(src_b);
`ifdef ALU_VECGEN_CORNER_EN
        begin
            int nxt_idx;
            nxt_idx = enter_run ? 0 : int'(count) + 1;
            if (nxt_idx < CORNERS) begin
                case (nxt_idx)
                    0:       begin vec_a = '0; vec_b = '0; end
                    1:       begin vec_a = '1; vec_b = '1; end
                    2:       begin vec_a = '1; vec_b = WIDTH'(1); end
                    default: begin
                        vec_a = WIDTH'(1) << (WIDTH - 1);
                        vec_b = WIDTH'(1) << (WIDTH - 1);
                    end
                endcase
            end
        end
`endif
    end

    // The final accept leaves a/b/op untouched so they hold through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else if (enter_run) begin
            count <= '0;
            a_q   <= vec_a;
            b_q   <= vec_b;
            op_q  <= '0;
        end else if (accept) begin
            count <= count + CNT_W'(1);
            if (!last) begin
                a_q  <= vec_a;
                b_q  <= vec_b;
                op_q <= (op_q == OP_W'(NUM_OPS - 1)) ? '0 : op_q + OP_W'(1);
            end
        end
    end

    assign vec.a     = a_q;
    assign vec.b     = b_q;
    assign vec.op    = op_q;
    assign vec.valid = busy;

endmodule

// File: tb/tb_alu_vector_gen.sv
// Directed bench for alu_vector_gen: a narrow (8-bit, 3 sets) and a wide
// (40-bit, 6 sets) instance checked against a queue of modelled vectors.
module tb_alu_vector_gen;

    localparam int          S_SETS = 3;
    localparam int          W_SETS = 6;
    localparam logic [31:0] MASK   = 32'h80200003;
    localparam logic [31:0] SALT   = 32'h9E3779B9;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  op;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_s, start_w;
    logic       busy_s, done_s, busy_w, done_w;
    logic [1:0] count_s;
    logic [2:0] count_w;

    int   checks = 0;
    int   errors = 0;
    int   sel;
    int   run_acc;
    logic rdy;
    vec_t sb_q[$];
    vec_t last_vec;

    alu_vector_gen_if #(.WIDTH(8),  .OP_W(3)) vif_s ();
    alu_vector_gen_if #(.WIDTH(40), .OP_W(3)) vif_w ();

    alu_vector_gen #(.WIDTH(8), .SETS(S_SETS), .NUM_OPS(8), .SEED(32'h1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .vec(vif_s),
        .busy(busy_s), .done(done_s), .count(count_s));

    alu_vector_gen #(.WIDTH(40), .SETS(W_SETS), .NUM_OPS(8), .SEED(32'h1)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .vec(vif_w),
        .busy(busy_w), .done(done_w), .count(count_w));

    always #5 clk = ~clk;

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ MASK;
        return n;
    endfunction

    // Expected vector idx of a run with SEED=1 for a given operand width.
    function automatic vec_t model_vec(input int width, input int idx);
        vec_t        v;
        logic [31:0] sa, sb;
        logic [63:0] m, wa, wb;
        int          r;
        sa   = 32'h1;
        sb   = 32'hFFFF_FFFE;
        r    = idx;
        m    = (64'd1 << width) - 64'd1;
        v.op = 3'(idx % 8);
`ifdef ALU_VECGEN_CORNER_EN
        if (idx < 4) begin
            case (idx)
                0:       begin v.a = 64'd0; v.b = 64'd0; end
                1:       begin v.a = m;     v.b = m;     end
                2:       begin v.a = m;     v.b = 64'd1; end
                default: begin v.a = 64'd1 << (width - 1); v.b = 64'd1 << (width - 1); end
            endcase
            return v;
        end
        r = idx - 4;
`endif
        for (int i = 0; i < r; i++) begin
            sa = model_step(sa);
            sb = model_step(sb);
        end
        wa  = {sa ^ SALT, sa};
        wb  = {sb ^ SALT, sb};
        v.a = wa & m;
        v.b = wb & m;
        return v;
    endfunction

    function automatic vec_t observe();
        vec_t v;
        if (sel == 0) begin
            v.a = 64'(vif_s.a); v.b = 64'(vif_s.b); v.op = vif_s.op;
        end else begin
            v.a = 64'(vif_w.a); v.b = 64'(vif_w.b); v.op = vif_w.op;
        end
        return v;
    endfunction

    function automatic logic obs_valid();
        return (sel == 0) ? vif_s.valid : vif_w.valid;
    endfunction
    function automatic logic obs_busy();
        return (sel == 0) ? busy_s : busy_w;
    endfunction
    function automatic logic obs_done();
        return (sel == 0) ? done_s : done_w;
    endfunction
    function automatic int obs_count();
        return (sel == 0) ? int'(count_s) : int'(count_w);
    endfunction

    task automatic set_ready(input logic r);
        rdy = r;
        if (sel == 0) vif_s.ready = r; else vif_w.ready = r;
    endtask

    task automatic set_start(input logic s);
        if (sel == 0) start_s = s; else start_w = s;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the whole run's expected vectors, then pulse start for one edge.
    task automatic apply_stimulus(input int n, input int width);
        for (int i = 0; i < n; i++) sb_q.push_back(model_vec(width, i));
        run_acc = 0;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
    endtask

    // Compare each accepted vector against the queue head; bounded by budget.
    task automatic collect(input int n, input int budget, output int cycles);
        int   got;
        vec_t exp_v, obs_v;
        got    = 0;
        cycles = 0;
        while (got < n && cycles < budget) begin
            if (obs_valid() && rdy) begin
                if (sb_q.size() == 0) begin
                    check_output("sb_underflow", 64'(sb_q.size()), 64'd1);
                end else begin
                    exp_v = sb_q.pop_front();
                    obs_v = observe();
                    check_output($sformatf("v%0d_a", run_acc), obs_v.a, exp_v.a);
                    check_output($sformatf("v%0d_b", run_acc), obs_v.b, exp_v.b);
                    check_output($sformatf("v%0d_op", run_acc), 64'(obs_v.op), 64'(exp_v.op));
                    check_output($sformatf("v%0d_count", run_acc), 64'(obs_count()), 64'(run_acc));
                    last_vec = exp_v;
                end
                got++;
                run_acc++;
            end
            cycles++;
            @(negedge clk);
        end
        check_output("accepts_within_budget", 64'(got), 64'(n));
    endtask

    task automatic check_done_state(input string tag, input int sets);
        vec_t obs_v;
        obs_v = observe();
        check_output({tag, "_done"},  64'(obs_done()),  64'd1);
        check_output({tag, "_busy"},  64'(obs_busy()),  64'd0);
        check_output({tag, "_valid"}, 64'(obs_valid()), 64'd0);
        check_output({tag, "_count"}, 64'(obs_count()), 64'(sets));
        check_output({tag, "_hold_a"},  obs_v.a, last_vec.a);
        check_output({tag, "_hold_b"},  obs_v.b, last_vec.b);
        check_output({tag, "_hold_op"}, 64'(obs_v.op), 64'(last_vec.op));
    endtask

    task automatic check_zero_state(input string tag);
        vec_t obs_v;
        obs_v = observe();
        check_output({tag, "_valid"}, 64'(obs_valid()), 64'd0);
        check_output({tag, "_busy"},  64'(obs_busy()),  64'd0);
        check_output({tag, "_done"},  64'(obs_done()),  64'd0);
        check_output({tag, "_count"}, 64'(obs_count()), 64'd0);
        check_output({tag, "_a"},  obs_v.a, 64'd0);
        check_output({tag, "_b"},  obs_v.b, 64'd0);
        check_output({tag, "_op"}, 64'(obs_v.op), 64'd0);
    endtask

    initial begin
        int   cyc;
        vec_t held;
        rst_n = 1'b0; start_s = 1'b0; start_w = 1'b0;
        vif_s.ready = 1'b0; vif_w.ready = 1'b0;
        rdy = 1'b0; sel = 0; run_acc = 0;

        repeat (2) @(negedge clk);
        check_zero_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero_state("idle");

        $display("[TB] basic run");
        set_ready(1'b1);
        apply_stimulus(S_SETS, 8);
`ifdef ALU_VECGEN_CORNER_EN
        check_output("first_a_const", 64'(vif_s.a), 64'h00);
        check_output("first_b_const", 64'(vif_s.b), 64'h00);
`else
        check_output("first_a_const", 64'(vif_s.a), 64'h01);
        check_output("first_b_const", 64'(vif_s.b), 64'hFE);
`endif
        collect(S_SETS, 20, cyc);
        check_output("basic_run_len", 64'(cyc), 64'(S_SETS));
        check_done_state("basic", S_SETS);
        @(negedge clk);
        check_output("done_sticky", 64'(done_s), 64'd1);

        $display("[TB] restart from DONE with backpressure and ignored start");
        apply_stimulus(S_SETS, 8);
        collect(1, 5, cyc);
        set_ready(1'b0);
        held = sb_q[0];
        for (int i = 0; i < 5; i++) begin
            set_start(i == 2);
            check_output($sformatf("stall%0d_valid", i), 64'(vif_s.valid), 64'd1);
            check_output($sformatf("stall%0d_a", i), 64'(vif_s.a), held.a);
            check_output($sformatf("stall%0d_b", i), 64'(vif_s.b), held.b);
            check_output($sformatf("stall%0d_op", i), 64'(vif_s.op), 64'(held.op));
            check_output($sformatf("stall%0d_count", i), 64'(count_s), 64'd1);
            @(negedge clk);
        end
        set_start(1'b0);
        set_ready(1'b1);
        collect(S_SETS - 1, 10, cyc);
        check_output("release_run_len", 64'(cyc), 64'(S_SETS - 1));
        check_done_state("bp", S_SETS);

        $display("[TB] reset mid-run");
        apply_stimulus(S_SETS, 8);
        collect(2, 10, cyc);
        check_output("pre_reset_count", 64'(count_s), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        check_zero_state("async_rst");
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(S_SETS, 8);
        collect(S_SETS, 20, cyc);
        check_output("post_reset_run_len", 64'(cyc), 64'(S_SETS));
        check_done_state("post_rst", S_SETS);

        $display("[TB] wide lanes");
        set_ready(1'b0);
        sel = 1;
        set_ready(1'b1);
        apply_stimulus(W_SETS, 40);
`ifdef ALU_VECGEN_CORNER_EN
        check_output("wide_first_a_const", 64'(vif_w.a), 64'h0);
`else
        check_output("wide_first_a_const", 64'(vif_w.a), 64'hB8_0000_0001);
`endif
        collect(W_SETS, 30, cyc);
        check_output("wide_run_len", 64'(cyc), 64'(W_SETS));
        check_done_state("wide", W_SETS);
        check_output("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_vector_gen.md
# alu_vector_gen

Parameterised stimulus source for the ALU test environment. On `start` it emits exactly `SETS` operand/opcode vectors (`a`, `b`, `op`) over a valid/ready handshake, then raises `done`. It is the producing end of the ALU input path, and its `WIDTH` and `SETS` are range-checked at elaboration by instantiating `Width_Check` and `Set_Check`.

## Interface
- `WIDTH`, 8: operand bit width; legal range 1..1024.
- `SETS`, 16: number of vectors per run; legal range 1..1000.
- `NUM_OPS`, 8: number of opcodes swept; ≥ 2. Local `OP_W = $clog2(NUM_OPS)`, `CNT_W = $clog2(SETS+1)`.
- `SEED`, 32'h1: LFSR A seed. LFSR B is seeded with `~SEED`. A zero seed is replaced by 32'h1.

Ports:
- `clk`  in  1  single clock; all state is rising-edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `start`  in  1  single-cycle run request. Honoured only in IDLE or DONE.
- `a`  out  WIDTH  operand A.
- `b`  out  WIDTH  operand B.
- `op`  out  OP_W  opcode.
- `valid`  out  1  vector on `a`/`b`/`op` is valid.
- `ready`  in  1  consumer accepts the vector when `valid && ready` at a clock edge.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `count`  out  CNT_W  number of vectors accepted in the current run.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE on the accept that makes `count == SETS`.
  - DONE → RUN on `start`.
  - All other events leave the state unchanged.
- Entering RUN:
  - Reload both LFSRs from their seeds.
  - Clear `count`.
  - Present vector 0.
- LFSR behaviour:
  - Both LFSRs are 32-bit Galois, right-shifting, mask 32'h80200003: `s = s[0] ? (s>>1)^MASK : s>>1`.
  - Both advance once per accepted random vector.
- Operand construction:
  - `a` is 32-bit lanes concatenated and truncated to `WIDTH`.
  - Lane k = `lfsr_a ^ (k * 32'h9E3779B9)`; lane 0 is the LSBs.
  - `b` is built the same way from `lfsr_b`.
- Opcode: `op = count % NUM_OPS`.
- Handshake:
  - While `valid` is high and `ready` is low, `a`, `b` and `op` hold stable.
  - `valid` never drops without an accept, except on reset.
- `start` while in RUN is ignored.
- `done` stays high until the next `start` or reset.
- Reset values:
  - State: IDLE.
  - `valid`, `busy`, `done`: 0.
  - `count`: 0.
  - `a`, `b`, `op`: 0.
  - LFSRs: their seeds.
- Reset mid-run aborts the run. No partial state survives.

## Timing
- `start` sampled at edge t → `valid=1`, `busy=1` from edge t (visible in cycle t+1).
- Back-to-back accepts:
  - With `ready` held high, one vector is accepted per cycle with no bubbles.
  - The next vector appears in the cycle after each accept.
- `count` increments at the accepting edge.
- Final accept at edge t → from edge t:
  - `valid=0`, `busy=0`, `done=1`.
  - `count == SETS`.
  - `a`/`b`/`op` hold their last values.
- Minimum run length: `SETS` cycles from the first `valid` to `done`.

## Configuration
- `ALU_VECGEN_CORNER_EN` defined:
  - The first `min(4,SETS)` vectors of each run are fixed corners: (0,0), (all-ones, all-ones), (all-ones, 1), (MSB-only, MSB-only).
  - LFSRs do not advance during corner vectors.
  - Corner vectors count toward `SETS`.
  - `op` still follows `count % NUM_OPS`.
- Undefined: every vector is LFSR-derived.

## Structure
- Shared package `alu_tb_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - `LFSR_MASK` = 32'h80200003;
  - `LANE_SALT` = 32'h9E3779B9;
  - the lane count function `(WIDTH+31)/32`.
- One sub-module, `lfsr32`: ports `clk`, `rst_n`, `load`, `seed`, `adv`, `state`. It is instantiated twice, for A and B.
- The top-level instantiates `Width_Check #(WIDTH)` and `Set_Check #(SETS)`.

## Test plan
- **Basic run.** WIDTH=8, SETS=3, SEED=1, `ready`=1, pulse `start`:
  - Vectors (a,b,op) = (8'h01,8'hFE,0), (8'h03,8'hFF,1), then the next LFSR step with op=2, on consecutive cycles.
  - `done`=1 and `count`=3 one edge after the third accept.
- **Backpressure.** `ready`=0 for 5 cycles mid-run:
  - `valid` stays 1; `a`, `b`, `op`, `count` are unchanged.
  - Release: accept on the first `ready` edge, then the sequence continues.
- **Wide lanes.** WIDTH=40, SEED=1: first `a` = 40'hB8_00000001 (lane 1 = 32'h9E3779B8, truncated to 8 bits).
- **Start handling.**
  - `start` pulsed during RUN: ignored, `count` is unaffected.
  - `start` in DONE: a new run repeats the identical vector sequence.
- **Reset mid-run.** `rst_n` low after 2 accepts:
  - All outputs read 0 immediately (asynchronous).
  - A subsequent `start` reproduces vector 0.
- **Corner mode.** `ALU_VECGEN_CORNER_EN`, WIDTH=8, SETS=6:
  - Vectors (00,00), (FF,FF), (FF,01), (80,80), then (01,FE), (03,FF); op = 0..5.
